// File: rtl/tick_period_meter.sv
// tick_period_meter: measures clk cycles between tick rising edges,
// range-checks each period and flags missing ticks and lost results.
module tick_period_meter #(
  parameter int CNT_W    = 32,
  parameter int EXPECTED = 33554433,
  parameter int TOL      = 0,
  parameter int TIMEOUT  = 67108866
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tick,
  input  logic             period_ready,
  output logic [CNT_W-1:0] period_data,
  output logic             period_valid,
  output logic             in_range,
  output logic             timeout,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    MEASURE
  } state_t;

  localparam int LO_I = (EXPECTED > TOL) ? EXPECTED - TOL : 0;
  localparam int HI_I = EXPECTED + TOL;

  localparam logic [CNT_W:0]   LO_W = (CNT_W+1)'(LO_I);
  localparam logic [CNT_W:0]   HI_W = (CNT_W+1)'(HI_I);
  localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             tick_d;
  logic             edge_s;
  logic             win;
  logic             xfer;

  logic [CNT_W-1:0] data_n;
  logic             valid_n;
  logic             inr_n;
  logic             to_n;
  logic             ov_n;

  assign edge_s = tick & ~tick_d;
  assign xfer   = period_valid & period_ready;
  assign win    = ({1'b0, cnt} >= LO_W) &&
                  ({1'b0, cnt} <= HI_W);
  assign busy   = (state == WAIT_FIRST) ||
                  (state == MEASURE);

  // State, counter, result and flag registers; tick delay runs always.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      tick_d       <= 1'b0;
      period_data  <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      timeout      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      tick_d       <= tick;
      period_data  <= data_n;
      period_valid <= valid_n;
      in_range     <= inr_n;
      timeout      <= to_n;
      overrun      <= ov_n;
    end
  end

  // Next state, counter and result; en low wipes everything.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = period_data;
    valid_n = period_valid;
    inr_n   = in_range;
    to_n    = timeout;
    ov_n    = overrun;

    if (xfer) begin
      valid_n = 1'b0;
    end

    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      data_n  = '0;
      valid_n = 1'b0;
      inr_n   = 1'b0;
      to_n    = 1'b0;
      ov_n    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_n   = '0;
          state_n = WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (edge_s) begin
            cnt_n   = ONE;
            to_n    = 1'b0;
            state_n = MEASURE;
          end
        end
        MEASURE: begin
          if (edge_s) begin
            data_n  = cnt;
            valid_n = 1'b1;
            inr_n   = win;
            cnt_n   = ONE;
            if (period_valid && !period_ready) begin
              ov_n = 1'b1;
            end
          end else if (cnt == TO_V) begin
            to_n    = 1'b1;
            cnt_n   = '0;
            state_n = WAIT_FIRST;
          end else if (cnt != '1) begin
            cnt_n = cnt + ONE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter: table vectors, corner sequences and random
// stimulus checked cycle by cycle against a timestamp model.
module tb_tick_period_meter;

  localparam int W   = 8;
  localparam int EXP = 10;
  localparam int TOL = 1;
  localparam int TO  = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         tick = 1'b0;
  logic         period_ready = 1'b0;
  logic [W-1:0] period_data;
  logic         period_valid;
  logic         in_range;
  logic         timeout;
  logic         overrun;
  logic         busy;

  tick_period_meter #(
    .CNT_W   (W),
    .EXPECTED(EXP),
    .TOL     (TOL),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .tick        (tick),
    .period_ready(period_ready),
    .period_data (period_data),
    .period_valid(period_valid),
    .in_range    (in_range),
    .timeout     (timeout),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Timestamp model: stage 0 idle, 1 armed, 2 measuring.
  int         n_cyc;
  int         m_stage;
  int         m_last;
  bit         m_pt;
  logic [W-1:0] m_data;
  bit         m_valid, m_inr, m_to, m_ov;

  typedef struct {
    int   gap;
    logic [W-1:0] data;
    logic inr;
  } vec_t;

  vec_t vecs[8];

  wire [12:0] dutv = {period_data, period_valid, in_range,
                      timeout, overrun, busy};

  function automatic logic [12:0] mexp();
    return {m_data, m_valid, m_inr, m_to, m_ov, (m_stage != 0)};
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_stage = 0;
    m_last  = 0;
    m_pt    = 1'b0;
    m_data  = '0;
    m_valid = 1'b0;
    m_inr   = 1'b0;
    m_to    = 1'b0;
    m_ov    = 1'b0;
  endtask

  task automatic model_step();
    bit ed = tick && !m_pt;
    bit v0 = m_valid;
    int el;
    m_pt = tick;
    n_cyc++;
    if (!en) begin
      model_reset();
      m_pt = tick;
    end else begin
      if (v0 && period_ready) m_valid = 1'b0;
      case (m_stage)
        0: m_stage = 1;
        1: if (ed) begin
          m_last  = n_cyc;
          m_stage = 2;
          m_to    = 1'b0;
        end
        default: begin
          el = n_cyc - m_last;
          if (ed) begin
            if (v0 && !period_ready) m_ov = 1'b1;
            m_valid = 1'b1;
            m_data  = W'(el);
            m_inr   = (el >= EXP - TOL) && (el <= EXP + TOL);
            m_last  = n_cyc;
          end else if (el == TO) begin
            m_to    = 1'b1;
            m_stage = 1;
          end
        end
      endcase
    end
  endtask

  task automatic cyc(input logic e, input logic t,
                     input logic r);
    en = e;
    tick = t;
    period_ready = r;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    chk("cycle", dutv, mexp());
  endtask

  task automatic pulse_gap(input int gap, input logic r);
    repeat (gap - 1) cyc(1'b1, 1'b0, r);
    cyc(1'b1, 1'b1, r);
  endtask

  initial begin
    int res;
    vecs[0] = '{gap: 10, data: 8'd10, inr: 1'b1};
    vecs[1] = '{gap: 10, data: 8'd10, inr: 1'b1};
    vecs[2] = '{gap: 12, data: 8'd12, inr: 1'b0};
    vecs[3] = '{gap:  9, data: 8'd9,  inr: 1'b1};
    vecs[4] = '{gap: 11, data: 8'd11, inr: 1'b1};
    vecs[5] = '{gap:  8, data: 8'd8,  inr: 1'b0};
    vecs[6] = '{gap: 19, data: 8'd19, inr: 1'b0};
    vecs[7] = '{gap: 20, data: 8'd20, inr: 1'b0};

    n_cyc = 0;
    model_reset();
    #1;
    chk("reset", dutv, 13'd0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;

    cyc(1'b1, 1'b0, 1'b1);
    chk("busy_wait", {busy, period_valid}, 2'b10);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("first_edge", period_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pulse_gap(vecs[i].gap, 1'b1);
      chk("table", {period_valid, period_data, in_range, overrun},
          {1'b1, vecs[i].data, vecs[i].inr, 1'b0});
    end

    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    repeat (7) cyc(1'b1, 1'b0, 1'b1);
    res = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        cyc(1'b1, 1'b1, 1'b1);
        res += int'(period_valid);
      end
      for (int i = 0; i < 6; i++) begin
        cyc(1'b1, 1'b0, 1'b1);
        res += int'(period_valid);
      end
    end
    chk("held_tick_results", res, 2);

    cyc(1'b1, 1'b1, 1'b1);
    repeat (19) cyc(1'b1, 1'b0, 1'b1);
    chk("timeout_early", timeout, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("timeout_set", {timeout, busy}, 2'b11);
    repeat (5) cyc(1'b1, 1'b0, 1'b1);
    chk("timeout_hold", {timeout, period_valid}, 2'b10);
    cyc(1'b1, 1'b1, 1'b1);
    chk("timeout_clr", {timeout, period_valid}, 2'b00);
    pulse_gap(10, 1'b1);
    chk("after_timeout", {period_valid, period_data},
        {1'b1, 8'd10});

    cyc(1'b1, 1'b0, 1'b1);
    repeat (8) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("stall_1", {period_valid, period_data, overrun},
        {1'b1, 8'd10, 1'b0});
    pulse_gap(12, 1'b0);
    chk("overrun", {period_valid, period_data, in_range, overrun},
        {1'b1, 8'd12, 1'b0, 1'b1});

    cyc(1'b0, 1'b0, 1'b0);
    chk("en_off", dutv, 13'd0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    pulse_gap(10, 1'b0);
    pulse_gap(10, 1'b0);
    chk("stall_2", {period_valid, period_data, overrun},
        {1'b1, 8'd10, 1'b1});
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    pulse_gap(10, 1'b0);
    repeat (9) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("xfer_and_load", {period_valid, period_data, overrun},
        {1'b1, 8'd10, 1'b0});
    cyc(1'b1, 1'b0, 1'b1);
    chk("valid_drop", period_valid, 1'b0);

    repeat (4) cyc(1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("reset_async", dutv, 13'd0);
    cyc(1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("rearm_first", period_valid, 1'b0);
    pulse_gap(10, 1'b1);
    chk("rearm_second", {period_valid, period_data},
        {1'b1, 8'd10});

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 63) != 0),
          ($urandom_range(0, 6) == 0),
          1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
